// File: rtl/i2s_tx.sv
// Stereo sample type shared with the effect pipeline, and the I2S bus-master
// transmitter that serialises samples through a small decoupling FIFO.
package sample_pkg;
  typedef struct packed {
    logic signed [15:0] lc;
    logic signed [15:0] rc;
  } sample_t;
endpackage

module i2s_tx #(
  parameter int BCLK_HALF  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  sample_pkg::sample_t data_i,
  input  logic                vld_i,
  input  logic                mute_i,
  output logic                rdy_o,
  output logic                bclk_o,
  output logic                lrclk_o,
  output logic                sdata_o,
  output logic                ovf_o,
  output logic                udr_o
);
  localparam int DIV_W = $clog2(BCLK_HALF);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [AW:0]      DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bclk_q, bclk_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic                lrclk_q, lrclk_d;
  logic [31:0]         sr_q, sr_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic                ovf_q, ovf_d;
  logic                udr_q, udr_d;
  sample_pkg::sample_t mem_q [FIFO_DEPTH];

  logic [AW:0]         count;
  logic                full, empty;
  logic                fall, load, pop, push;
  sample_pkg::sample_t head;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    div_d     = div_q;
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sr_d      = sr_q;
    udr_d     = 1'b0;
    fall      = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;

    if (div_q == DIV_LAST) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
      fall   = bclk_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // Serial state only moves on BCLK falling edges.
    if (fall) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      lrclk_d   = bit_cnt_d[4];
      load      = (bit_cnt_d == 5'd1);
      if (load) begin
        if (empty) begin
          sr_d  = '0;
          udr_d = 1'b1;
        end else begin
          pop  = 1'b1;
          sr_d = mute_i ? 32'h0 : head;
        end
      end else begin
        sr_d = {sr_q[30:0], 1'b0};
      end
    end
  end

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  always_comb begin
    push     = vld_i && (!full || pop);
    ovf_d    = vld_i && !push;
    wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      lrclk_q   <= 1'b0;
      sr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      udr_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      sr_q      <= sr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      udr_q     <= udr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  assign rdy_o   = (count < DEPTH_C);
  assign bclk_o  = bclk_q;
  assign lrclk_o = lrclk_q;
  assign sdata_o = sr_q[31];
  assign ovf_o   = ovf_q;
  assign udr_o   = udr_q;

endmodule
